// File: rtl/arith_pkg.sv
// Shared arithmetic helpers for the pipelined add/subtract datapath.
// Covers slice sizing, parameter legality and operation encoding.
package arith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int slice_w(input int n, input int stages);
        return n / stages;
    endfunction

    function automatic bit params_ok(input int n, input int stages);
        return (stages >= 1) && ((n % stages) == 0);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational W-bit adder slice with carry in and carry out.
// Each pipeline stage uses one slice to resolve its W result bits.
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};

endmodule

// File: rtl/pipelined_nbit_addsub.sv
// N-bit add/subtract with a STAGES-deep carry pipeline and valid/ready handshakes.
// Each stage resolves one slice and forwards its carry, the results so far, and the operand bits not yet used.
module pipelined_nbit_addsub
    import arith_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf
);

    localparam int W = slice_w(N, STAGES);

    if (!params_ok(N, STAGES)) begin : g_bad_params
        $error("pipelined_nbit_addsub: N must be a multiple of STAGES and STAGES >= 1");
    end

    logic [N-1:0] bPrime;
    logic         cinPrime;

    // Subtraction is a + ~b + ~c_in, so a set borrow-in clears the adder carry.
    assign bPrime   = (sub == OP_SUB) ? ~b : b;
    assign cinPrime = (sub == OP_ADD) ? c_in : ~c_in;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] cryVec;
    logic [STAGES-1:0] sgnAVec;
    logic [STAGES-1:0] sgnBVec;
    logic [N-1:0]      resVec   [STAGES];
    logic [N-1:0]      skewAVec [STAGES];
    logic [N-1:0]      skewBVec [STAGES];

    // Ready chain: a stage may load if it is empty or if everything below it advances.
    // Empty stages therefore fill even while the output is stalled.
    always_comb begin
        logic take;
        take = out_ready;
        ld   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = !vld[k] || take;
            take  = ld[k];
        end
    end

    assign in_ready = ld[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SKEW = N - (k + 1) * W;

        logic                   vld_q;
        logic [(k+1)*W-1:0]     res_q;
        logic [(k+1)*W-1:0]     res_d;
        logic                   cry_q;
        logic                   sgnA_q;
        logic                   sgnB_q;
        logic                   vIn;
        logic                   cIn;
        logic                   sAIn;
        logic                   sBIn;
        logic [W-1:0]           opA;
        logic [W-1:0]           opB;
        logic [W-1:0]           sliceSum;
        logic                   sliceCout;

        if (k == 0) begin : g_src
            assign vIn   = in_valid;
            assign opA   = a[W-1:0];
            assign opB   = bPrime[W-1:0];
            assign cIn   = cinPrime;
            assign sAIn  = a[N-1];
            assign sBIn  = bPrime[N-1];
            assign res_d = sliceSum;
        end else begin : g_src
            assign vIn   = vld[k-1];
            assign opA   = skewAVec[k-1][W-1:0];
            assign opB   = skewBVec[k-1][W-1:0];
            assign cIn   = cryVec[k-1];
            assign sAIn  = sgnAVec[k-1];
            assign sBIn  = sgnBVec[k-1];
            assign res_d = {sliceSum, resVec[k-1][k*W-1:0]};
        end

        addsub_slice #(.W(W)) u_slice (
            .a_i (opA),
            .b_i (opB),
            .c_i (cIn),
            .s_o (sliceSum),
            .c_o (sliceCout)
        );

        // Data only moves with a real beat, so an idle output keeps its last result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                res_q  <= '0;
                cry_q  <= 1'b0;
                sgnA_q <= 1'b0;
                sgnB_q <= 1'b0;
            end else if (ld[k]) begin
                vld_q <= vIn;
                if (vIn) begin
                    res_q  <= res_d;
                    cry_q  <= sliceCout;
                    sgnA_q <= sAIn;
                    sgnB_q <= sBIn;
                end
            end
        end

        if (SKEW > 0) begin : g_skew
            logic [SKEW-1:0] skewA_q;
            logic [SKEW-1:0] skewB_q;
            logic [SKEW-1:0] skewA_d;
            logic [SKEW-1:0] skewB_d;

            if (k == 0) begin : g_ld
                assign skewA_d = a[N-1:W];
                assign skewB_d = bPrime[N-1:W];
            end else begin : g_ld
                assign skewA_d = skewAVec[k-1][SKEW+W-1:W];
                assign skewB_d = skewBVec[k-1][SKEW+W-1:W];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skewA_q <= '0;
                    skewB_q <= '0;
                end else if (ld[k] && vIn) begin
                    skewA_q <= skewA_d;
                    skewB_q <= skewB_d;
                end
            end

            assign skewAVec[k] = N'(skewA_q);
            assign skewBVec[k] = N'(skewB_q);
        end else begin : g_noskew
            assign skewAVec[k] = '0;
            assign skewBVec[k] = '0;
        end

        assign vld[k]     = vld_q;
        assign resVec[k]  = N'(res_q);
        assign cryVec[k]  = cry_q;
        assign sgnAVec[k] = sgnA_q;
        assign sgnBVec[k] = sgnB_q;
    end

    assign out_valid = vld[STAGES-1];
    assign sum       = resVec[STAGES-1];
    assign c_out     = cryVec[STAGES-1];
    assign ovf       = (sgnAVec[STAGES-1] == sgnBVec[STAGES-1]) && (sum[N-1] != sgnAVec[STAGES-1]);

endmodule

// File: doc/pipelined_nbit_addsub.md
Name: pipelined_nbit_addsub

Overview:
- Parametrised successor to the team's N-bit add-with-carry block.
- Adds or subtracts two N-bit operands through a STAGES-deep carry-pipelined datapath. Each stage resolves one N/STAGES-bit slice and registers its carry into the next stage.
- Valid/ready handshakes on both sides with per-stage backpressure, so it drops into streaming datapaths (ALU, accumulators) at full throughput and higher clock rate.
- Adds subtract mode and a signed-overflow flag.

Parameters:
- N, 32: operand/result width in bits.
- STAGES, 4: number of pipeline stages (slices). N % STAGES must equal 0 and STAGES >= 1; other values are a compile-time error.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- c_in  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = a+b+c_in, 1 = a-b-c_in.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  N  result bits.
- c_out  out  1  raw carry out of the MSB slice.
- ovf  out  1  two's-complement signed overflow of the operation.

Behaviour:
- Slice width W = N/STAGES. Stage k (0..STAGES-1) computes bits [k*W +: W].
- Arithmetic:
  - Adder operand is B' = sub ? ~b : b.
  - Adder carry-in is cin' = sub ? ~c_in : c_in.
  - Result is {c_out, sum} = a + B' + cin', computed modulo 2^(N+1).
  - In sub mode c_out = 1 means no borrow.
- ovf = (a[N-1] == B'[N-1]) && (sum[N-1] != a[N-1]).
- Stage k registers:
  - its valid bit;
  - its slice result;
  - its carry-out;
  - lower result slices passed through;
  - upper, not-yet-consumed operand slices (skew registers);
  - the MSB sign bits needed for ovf.
- Stage 0 consumes cin'. Stage k consumes stage k-1's registered carry.
- Latency: exactly STAGES cycles from an accepted input (in_valid && in_ready) to out_valid, when not stalled. With STAGES=1 the block is a single registered adder.
- Throughput: one beat per cycle while out_ready = 1.
- Stall rule, per stage:
  - Stage k loads when its own register is empty, or when stage k+1 (or the output, for the last stage) takes its contents this cycle.
  - in_ready = stage-0 load enable. in_ready never depends combinationally on in_valid. It may depend combinationally on out_ready through the ready chain.
  - Bubbles collapse: a stalled output does not block upstream empty stages from filling.
- Outputs are driven directly from last-stage registers. While out_valid=1 && out_ready=0, sum, c_out and ovf hold stable.
- Reset (rst_n low, asynchronous):
  - all valid bits clear, so out_valid=0 and in_ready=1 after release;
  - sum=0, c_out=0, ovf=0;
  - all data/skew/carry registers cleared.
- Reset asserted mid-operation drops every in-flight beat. No partial result is ever presented.
- Boundaries:
  - all-ones + 1 wraps to 0 with c_out=1;
  - carry must cross every slice boundary correctly in one pass through the pipeline;
  - simultaneous output pop and input push with a full pipe sustains full rate, with no lost or duplicated beats;
  - out_ready asserted without out_valid has no effect.

Decomposition:
- Shared package (arith_pkg):
  - function slice_w(N, STAGES);
  - localparam checks / assertion macro for N % STAGES;
  - op encoding constants OP_ADD=0, OP_SUB=1.
- One natural sub-module, addsub_slice: a combinational W-bit add with carry-in, returning slice sum and carry-out. It is instantiated once per stage via generate. Pipeline registers and handshake live in the top.

Test Plan:
- N=32, STAGES=4, out_ready=1: a=0x0000_0005, b=0x0000_0003, c_in=0, sub=0 -> after 4 cycles sum=0x0000_0008, c_out=0, ovf=0.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, c_in=1, sub=0 -> sum=0x0000_0000, c_out=1, ovf=0. Also a=0x7FFF_FFFF, b=1, c_in=0 -> sum=0x8000_0000, ovf=1.
- Subtract: a=0x0000_0003, b=0x0000_0005, c_in=0, sub=1 -> sum=0xFFFF_FFFE, c_out=0 (borrow). a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, ovf=1.
- Backpressure: stream 10 beats (a=i, b=i*3) with out_ready toggled in a 1-on/2-off pattern -> 10 results in order, each equal to 4*i; in_ready=0 only while all 4 stages are full; outputs stable while stalled.
- Reset mid-flight: push 3 beats, assert rst_n=0 for 1 cycle at cycle 2 -> out_valid=0 and sum=0 immediately; no result emerges afterwards; next pushed beat appears exactly 4 cycles after acceptance.
- STAGES=1 and STAGES=8 builds (N=32): random 1000-beat stream versus a reference model -> bit-exact sum/c_out/ovf, with latency equal to STAGES.
